// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: UART receive front end (8N1, LSB first, idle-high line).
// Turns the raw serial line into bytes behind a valid/ready handshake and
// keeps sticky framing/overrun/parity status bits for software polling.
//
// Ports:
//   clk             core clock, all state changes on the rising edge
//   rst             asynchronous active-high reset
//   serial_in       asynchronous RX line, idles high
//   data_out        received byte, stable while data_out_valid=1
//   data_out_valid  byte available
//   data_out_ready  consumer accepts the byte
//   framing_error   sticky, a stop bit was sampled low
//   overrun         sticky, a byte was dropped because the output was full
//   parity_error    sticky, even-parity check failed (0 unless parity build)
//   err_clear       one-cycle pulse clearing all sticky flags
//   busy            receiver is inside a frame (not IDLE)
//
// Build option: define UART_RX_PARITY_EN for 8E1 frames with a PARITY state.
module uart_rx_deframer #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       framing_error,
    output logic       overrun,
    output logic       parity_error,
    input  logic       err_clear,
    output logic       busy
);

    // Clocks per bit and clocks to mid-bit; derived, never overridden.
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CW               = $clog2(SYMBOL_EDGE_TIME) + 1;

    localparam logic [CW-1:0] C_MID_LAST = CW'(SAMPLE_TIME - 1);
    localparam logic [CW-1:0] C_BIT_LAST = CW'(SYMBOL_EDGE_TIME - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    // Two-flop synchronizer; both flops reset to the idle line level.
    logic          r_sync1;
    logic          r_sync2;
    logic          w_rx_s;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_cnt_last;

    logic [2:0]    r_bit_idx;
    logic [2:0]    w_bit_idx_nxt;

    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nxt;

    logic [7:0]    r_data;
    logic [7:0]    w_data_nxt;
    logic          r_valid;
    logic          w_valid_nxt;

    logic          r_framing_err;
    logic          r_overrun;

    // Frame-level events produced by the state machine.
    logic          w_stop_ok;
    logic          w_fe_set;
    logic          w_ov_set;
    logic          w_load;

`ifdef UART_RX_PARITY_EN
    logic          r_parity_err;
    logic          w_pe_set;
`endif

    assign w_rx_s     = r_sync2;
    assign w_cnt_last = (r_cnt == C_BIT_LAST);

    // ------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= serial_in;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // State register and frame datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and frame events
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_stop_ok     = 1'b0;
        w_fe_set      = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_pe_set      = 1'b0;
`endif

        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_rx_s) begin
                    w_state_nxt = S_START;
                end
            end

            S_START: begin
                if (r_cnt == C_MID_LAST) begin
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = '0;
                    // A line already back high at mid-start is a glitch.
                    w_state_nxt   = w_rx_s ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            S_DATA: begin
                if (w_cnt_last) begin
                    // LSB first: right shift so bit 0 ends up in [0].
                    w_shift_nxt   = {w_rx_s, r_shift[7:1]};
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_cnt_last) begin
                    // Even parity: data bits plus parity bit XOR to 0.
                    w_pe_set    = ^{r_shift, w_rx_s};
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
`endif

            S_STOP: begin
                if (w_cnt_last) begin
                    // Leave at mid-stop so the next start edge is not missed.
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                    if (w_rx_s) begin
                        w_stop_ok = 1'b1;
                    end else begin
                        w_fe_set  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output buffer: a good frame loads when the buffer is empty or is
    // being drained this very cycle; otherwise the new byte is dropped.
    // ------------------------------------------------------------------
    always_comb begin
        w_load      = w_stop_ok & (~r_valid | data_out_ready);
        w_ov_set    = w_stop_ok & r_valid & ~data_out_ready;
        w_valid_nxt = w_load | (r_valid & ~data_out_ready);
        w_data_nxt  = w_load ? r_shift : r_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Sticky status: a set event beats a same-cycle clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_framing_err <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_framing_err <= (r_framing_err & ~err_clear) | w_fe_set;
            r_overrun     <= (r_overrun & ~err_clear) | w_ov_set;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= (r_parity_err & ~err_clear) | w_pe_set;
        end
    end

    assign parity_error = r_parity_err;
`else
    assign parity_error = 1'b0;
`endif

    assign data_out       = r_data;
    assign data_out_valid = r_valid;
    assign framing_error  = r_framing_err;
    assign overrun        = r_overrun;
    assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: directed bench for uart_rx_deframer at default rates.
// Drives whole frames bit-by-bit and checks outputs with immediate asserts.
module tb_uart_rx_deframer;

    localparam int BIT = 434;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 4125 + BIT;
`else
    localparam int LAT = 4125;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       serial_in = 1'b1;
    logic       data_out_ready = 1'b0;
    logic       err_clear = 1'b0;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       framing_error;
    logic       overrun;
    logic       parity_error;
    logic       busy;

    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    int         rise_cyc = -1;
    int         start_cyc = 0;
    logic       prev_v = 1'b0;
`ifdef UART_RX_PARITY_EN
    logic       pflip = 1'b0;
`endif

    uart_rx_deframer dut (
        .clk            (clk),
        .rst            (rst),
        .serial_in      (serial_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .framing_error  (framing_error),
        .overrun        (overrun),
        .parity_error   (parity_error),
        .err_clear      (err_clear),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_out_valid && !prev_v) rise_cyc = cyc;
        prev_v = data_out_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; each bit is held exactly BIT clocks.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        serial_in = 1'b0;
        start_cyc = cyc;
        step(BIT);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            step(BIT);
        end
`ifdef UART_RX_PARITY_EN
        serial_in = ^b ^ pflip;
        step(BIT);
`endif
        serial_in = stop;
        step(BIT);
        serial_in = 1'b1;
    endtask

    task automatic pulse_ready();
        data_out_ready = 1'b1;
        step(1);
        data_out_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        step(1);
        err_clear = 1'b0;
    endtask

    initial begin
        int d;

        // Reset held with idle line
        step(10);
        @(negedge clk);
        chk("rst_data", data_out, 0);
        chk("rst_valid", data_out_valid, 0);
        chk("rst_fe", framing_error, 0);
        chk("rst_ov", overrun, 0);
        chk("rst_pe", parity_error, 0);
        chk("rst_busy", busy, 0);
        step(1);
        rst = 1'b0;
        step(20);

        // Single byte 0xA5 with latency check
        rise_cyc = -1;
        send_frame(8'hA5, 1'b1);
        d = rise_cyc - start_cyc;
        chk("a5_latency", (rise_cyc >= 0 && d >= LAT - 1 && d <= LAT + 1), 1);
        chk("a5_data", data_out, 8'hA5);
        chk("a5_valid", data_out_valid, 1);
        step(300);
        chk("a5_hold", data_out_valid, 1);
        pulse_ready();
        @(negedge clk);
        chk("a5_consumed", data_out_valid, 0);
        chk("a5_fe", framing_error, 0);

        // Start glitch of 100 clocks
        step(1);
        serial_in = 1'b0;
        step(50);
        chk("gl_busy_mid", busy, 1);
        step(50);
        serial_in = 1'b1;
        step(400);
        @(negedge clk);
        chk("gl_busy", busy, 0);
        chk("gl_valid", data_out_valid, 0);
        chk("gl_fe", framing_error, 0);
        chk("gl_ov", overrun, 0);

        // Framing error on 0x3C
        step(1);
        send_frame(8'h3C, 1'b0);
        step(1000);
        @(negedge clk);
        chk("fe_set", framing_error, 1);
        chk("fe_valid", data_out_valid, 0);
        chk("fe_busy", busy, 0);
        pulse_clear();
        @(negedge clk);
        chk("fe_clear", framing_error, 0);

        // Overrun: 0x11 then 0x22 back-to-back, never consumed
        step(1);
        send_frame(8'h11, 1'b1);
        chk("ov_first_data", data_out, 8'h11);
        chk("ov_first_ov", overrun, 0);
        send_frame(8'h22, 1'b1);
        @(negedge clk);
        chk("ov_data", data_out, 8'h11);
        chk("ov_valid", data_out_valid, 1);
        chk("ov_set", overrun, 1);
        pulse_clear();
        @(negedge clk);
        chk("ov_clear", overrun, 0);

        // 0x22 again, ready pulsed on the stop-sample cycle
        step(1);
        fork
            send_frame(8'h22, 1'b1);
            begin
                step(LAT);
                data_out_ready = 1'b1;
                step(1);
                data_out_ready = 1'b0;
            end
        join
        @(negedge clk);
        chk("sim_data", data_out, 8'h22);
        chk("sim_valid", data_out_valid, 1);
        chk("sim_ov", overrun, 0);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 with parity bit 0 is wrong, with 1 is right
        pulse_ready();
        pflip = 1'b1;
        send_frame(8'h07, 1'b1);
        @(negedge clk);
        chk("par_bad_pe", parity_error, 1);
        chk("par_bad_data", data_out, 8'h07);
        chk("par_bad_valid", data_out_valid, 1);
        pulse_clear();
        pulse_ready();
        pflip = 1'b0;
        send_frame(8'h07, 1'b1);
        @(negedge clk);
        chk("par_ok_pe", parity_error, 0);
        chk("par_ok_data", data_out, 8'h07);
        chk("par_ok_valid", data_out_valid, 1);
`endif

        // Asynchronous reset mid-DATA with a byte still buffered
        step(1);
        serial_in = 1'b0;
        step(BIT);
        serial_in = 1'b1;
        step(2 * BIT);
        @(negedge clk);
        chk("mid_busy", busy, 1);
        step(1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_data", data_out, 0);
        chk("arst_valid", data_out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ov", overrun, 0);
        step(3);
        rst = 1'b0;
        step(12 * BIT);
        @(negedge clk);
        chk("post_valid", data_out_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_data", data_out, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
Serial receive front end feeding the CPU's memory-mapped UART receive path. It sits directly upstream of the CPU's `serial_in` consumer: it turns the raw line into bytes and presents them through a valid/ready handshake. Frame format is 8N1, LSB first, idle-high line. Framing errors and overruns are flagged as sticky status bits that software can poll.

Parameters:
- CLOCK_FREQ, 50_000_000, core clock in Hz.
- BAUD_RATE, 115_200, line rate in bit/s.
- SYMBOL_EDGE_TIME is derived, not overridable: CLOCK_FREQ/BAUD_RATE, integer-truncated, clocks per bit (434 at defaults).
- SAMPLE_TIME is derived, not overridable: SYMBOL_EDGE_TIME/2, clocks to mid-bit (217 at defaults).

Ports:
- clk  in  1  core clock; all state changes on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- serial_in  in  1  asynchronous RX line; idles at 1.
- data_out  out  8  received byte; stable while data_out_valid=1.
- data_out_valid  out  1  byte available.
- data_out_ready  in  1  consumer accepts the byte.
- framing_error  out  1  sticky; a stop bit was sampled 0.
- overrun  out  1  sticky; a byte was dropped because the output was still full.
- parity_error  out  1  sticky; see Optional Feature.
- err_clear  in  1  one-cycle pulse; clears all sticky flags.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert): state=IDLE, bit-period counter=0, bit index=0, shift register=0.
  - Both synchronizer flops reset to 1.
  - data_out=0, data_out_valid=0, framing_error=0, overrun=0, parity_error=0, busy=0.
  - Reset mid-frame abandons the frame; no partial byte is ever delivered.
- Input synchronizer: two flops. `rx_s` is the second flop. All decisions use `rx_s`, so there are 2 cycles of input latency.
- State machine:
  - IDLE: if rx_s=0, go to START and clear the counter.
  - START: count up. At counter==SAMPLE_TIME-1, sample rx_s:
    - 0: go to DATA, clear counter and bit index.
    - 1: treat as a glitch, return to IDLE, no flags set.
  - DATA: at counter==SYMBOL_EDGE_TIME-1, shift rx_s into the MSB of the shift register (right shift, so the first bit lands in bit 0 after 8 shifts). Clear the counter and increment the bit index. After the 8th bit, go to STOP (or PARITY when the optional feature is enabled).
  - STOP: at counter==SYMBOL_EDGE_TIME-1, sample rx_s, then go to IDLE.
    - 1: frame is good; deliver it (rules below).
    - 0: set framing_error; discard the byte.
- Delivery at a good stop sample:
  - If data_out_valid=0, or data_out_ready=1 in the same cycle: load data_out, data_out_valid=1.
  - Otherwise: keep the old data_out, set overrun, drop the new byte.
- Handshake: a transfer occurs on a cycle where data_out_valid & data_out_ready.
  - data_out_valid drops the next cycle unless a new byte is loaded in that same cycle. A simultaneous consume and load leaves valid=1 with the new byte and no overrun.
  - data_out_ready while valid=0 is ignored.
- Latency: the line falling edge to valid rising is 2 + SAMPLE_TIME + 9×SYMBOL_EDGE_TIME clocks, ±1 for synchronizer phase (4125 at defaults, 8N1).
- Back-to-back frames: the return to IDLE happens at the mid-stop sample, so the next start edge is caught with no dead time.
- Sticky flags:
  - Set only by the events above; cleared only by err_clear or rst.
  - err_clear in the same cycle as a setting event: the set wins.
- Counter width: $clog2(SYMBOL_EDGE_TIME)+1 bits; no wrap inside a bit period.

Optional Feature:
- Macro `UART_RX_PARITY_EN`.
- Defined:
  - Frame is 8E1.
  - A PARITY state sits after DATA and samples at SYMBOL_EDGE_TIME-1.
  - Parity error when the XOR of the 8 data bits and the parity bit is 1. The error sets parity_error; the byte is still delivered if the stop bit is 1.
  - Latency grows by SYMBOL_EDGE_TIME.
- Undefined:
  - No PARITY state.
  - parity_error is tied to 0.
  - Frame is 8N1.

Test Plan:
- Reset: hold rst=1 for 10 cycles with serial_in=1. All outputs are 0 and busy=0. Assert rst asynchronously mid-DATA: outputs clear immediately and no byte appears afterwards.
- Single byte: send 0xA5 at 434 clk/bit. data_out_valid rises 4125±1 clks after the start edge with data_out=0xA5. Hold data_out_ready=0 and check valid stays 1; pulse ready and check valid=0 the next cycle.
- Glitch: drive serial_in=0 for 100 clks, then 1. State returns to IDLE; no valid and no flags.
- Framing: send 0x3C with stop bit=0. framing_error=1 and valid stays 0. An err_clear pulse brings it back to 0.
- Overrun and simultaneous consume: send 0x11 then 0x22 back-to-back with ready=0. data_out=0x11 and overrun=1. Repeat with ready pulsed exactly on the 0x22 stop-sample cycle: data_out=0x22, valid stays 1, overrun=0.
- `UART_RX_PARITY_EN`: send 0x07 with parity bit 0 (odd ones plus 0). parity_error=1 and data_out=0x07 is delivered. Send 0x07 with parity bit 1: no error.
